// File: rtl/sb_map_pkg.sv
// Shared constants and types for the multi-region system-bus memory controller.
package sb_map_pkg;

    localparam int unsigned CSR_FILL_DATA  = 0;
    localparam int unsigned CSR_FILL_CMD   = 1;
    localparam int unsigned CSR_ERR_COUNT  = 2;
    localparam int unsigned CSR_WORDS      = 3;
    localparam int unsigned FILL_START_BIT = 31;

    localparam logic [31:0] UNMAPPED_RDATA = 32'h0;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_RUN,
        FILL_DONE
    } fill_state_t;

endpackage

// File: rtl/sb_map_bank.sv
// One DEPTH x 32 dual-port RAM: port A read/write with byte enables, port B read-only.
module sb_map_bank
    import sb_map_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_a,
    input  logic          re_a,
    input  logic [3:0]    be_a,
    input  logic [AW-1:0] addr_a,
    input  logic [31:0]   wdata_a,
    output logic [31:0]   rdata_a,
    input  logic [AW-1:0] addr_b,
    output logic [31:0]   rdata_b
);

    logic [31:0] mem [DEPTH];

    // Both ports are read-first: reads sample the array before this edge's write lands.
    always_ff @(posedge clk_i) begin
        if (we_a) begin
            for (int b = 0; b < 4; b++) begin
                if (be_a[b]) mem[addr_a][8*b +: 8] <= wdata_a[8*b +: 8];
            end
        end
        if (re_a) rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/sb_multimap_ctrl.sv
// System-bus slave over NUM_REGIONS word memories with display read ports,
// a hardware fill engine, stall handshake and unmapped-access error reporting.
module sb_multimap_ctrl
    import sb_map_pkg::*;
#(
    parameter  int unsigned NUM_REGIONS    = 3,
    parameter  int unsigned DEPTH          = 1024,
    parameter  int unsigned REGION_SEL_LSB = 12,
    parameter  int unsigned ERR_CNT_W      = 16,
    localparam int unsigned SEL_W          = $clog2(NUM_REGIONS + 1),
    localparam int unsigned AW             = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [3:0]       mem_be_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic             ready_o,
    output logic [31:0]      read_data_o,
    output logic             err_o,
    input  logic [SEL_W-1:0] disp_region_i,
    input  logic [AW-1:0]    disp_addr_i,
    output logic [31:0]      disp_rdata_o,
    output logic             fill_busy_o,
    output logic             fill_done_o
);

    localparam int unsigned RGN_W = 32 - REGION_SEL_LSB;
    localparam int unsigned WRD_W = REGION_SEL_LSB - 2;
    localparam int unsigned NSLOT = 1 << SEL_W;

    fill_state_t          state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]     fill_tgt_q, fill_tgt_d;
    logic [31:0]          fill_pat_q, fill_pat_d;
    logic [31:0]          fill_data_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [SEL_W-1:0]     rd_src_q;
    logic [SEL_W-1:0]     disp_sel_q;
    logic [31:0]          csr_rdata_q;
    logic [31:0]          csr_rdata_c;

    logic [RGN_W-1:0] rgn;
    logic [WRD_W-1:0] wrd;
    logic [SEL_W-1:0] rgn_idx;
    logic             is_bank, is_csr, word_ok, csr_ok, mapped, acc;
    logic             start_req, tgt_ok, fill_go, err_ev;
    logic             addr_unused;

    logic [31:0] bank_rd_a [NSLOT];
    logic [31:0] bank_rd_b [NSLOT];

    // Address decode: anything above the top region or beyond DEPTH words is unmapped.
    assign rgn         = addr_i[31:REGION_SEL_LSB];
    assign wrd         = addr_i[REGION_SEL_LSB-1:2];
    assign rgn_idx     = rgn[SEL_W-1:0];
    assign addr_unused = ^addr_i[1:0];
    assign is_bank     = rgn < RGN_W'(NUM_REGIONS);
    assign is_csr      = rgn == RGN_W'(NUM_REGIONS);
    assign word_ok     = (wrd >> AW) == '0;
    assign csr_ok      = wrd < WRD_W'(CSR_WORDS);
    assign mapped      = (is_bank && word_ok) || (is_csr && csr_ok);

    assign fill_busy_o = (state_q == FILL_RUN);
    assign fill_done_o = (state_q == FILL_DONE);
    assign ready_o     = !(fill_busy_o && req_i && (rgn == RGN_W'(fill_tgt_q)));
    assign acc         = req_i && ready_o;

    // Reserved target bits must be zero, so an out-of-range target cannot alias a real region.
    assign start_req = acc && write_enable_i && is_csr && (wrd == WRD_W'(CSR_FILL_CMD))
                       && write_data_i[FILL_START_BIT];
    assign tgt_ok    = (write_data_i[30:SEL_W] == '0)
                       && (write_data_i[SEL_W-1:0] < SEL_W'(NUM_REGIONS));
    assign fill_go   = start_req && tgt_ok && (state_q == FILL_IDLE);
    assign err_ev    = (acc && !mapped) || (start_req && !fill_go);

    always_comb begin
        csr_rdata_c = UNMAPPED_RDATA;
        if (is_csr) begin
            if (wrd == WRD_W'(CSR_FILL_DATA))      csr_rdata_c = fill_data_q;
            else if (wrd == WRD_W'(CSR_FILL_CMD))  csr_rdata_c = 32'({fill_tgt_q, fill_busy_o});
            else if (wrd == WRD_W'(CSR_ERR_COUNT)) csr_rdata_c = 32'(err_cnt_q);
        end
    end

    // Fill engine state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FILL_IDLE;
            cnt_q      <= '0;
            fill_tgt_q <= '0;
            fill_pat_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_tgt_q <= fill_tgt_d;
            fill_pat_q <= fill_pat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_tgt_d = fill_tgt_q;
        fill_pat_d = fill_pat_q;
        case (state_q)
            FILL_IDLE: begin
                if (fill_go) begin
                    state_d    = FILL_RUN;
                    cnt_d      = '0;
                    fill_tgt_d = write_data_i[SEL_W-1:0];
                    fill_pat_d = fill_data_q;
                end
            end
            FILL_RUN: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) state_d = FILL_DONE;
            end
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase
    end

    // CSRs, error reporting and read-source capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_data_q <= '0;
            err_cnt_q   <= '0;
            err_o       <= 1'b0;
            rd_src_q    <= SEL_W'(NUM_REGIONS);
            csr_rdata_q <= '0;
            disp_sel_q  <= SEL_W'(NUM_REGIONS);
        end else begin
            err_o      <= err_ev;
            disp_sel_q <= disp_region_i;
            if (err_ev && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            if (acc && write_enable_i && is_csr && (wrd == WRD_W'(CSR_FILL_DATA))) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_i[b]) fill_data_q[8*b +: 8] <= write_data_i[8*b +: 8];
                end
            end
            if (acc && !write_enable_i) begin
                rd_src_q    <= (is_bank && word_ok) ? rgn_idx : SEL_W'(NUM_REGIONS);
                csr_rdata_q <= csr_rdata_c;
            end
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_bank
        if (g < NUM_REGIONS) begin : g_mem
            logic own, hit;
            // The fill engine owns port A of its target bank; the bus is stalled off that bank.
            assign own = fill_busy_o && (fill_tgt_q == SEL_W'(g));
            assign hit = acc && is_bank && word_ok && (rgn_idx == SEL_W'(g));

            sb_map_bank #(.DEPTH(DEPTH)) u_bank (
                .clk_i   (clk_i),
                .we_a    (!rst_i && (own || (hit && write_enable_i))),
                .re_a    (!rst_i && !own && hit && !write_enable_i),
                .be_a    (own ? 4'hF : mem_be_i),
                .addr_a  (own ? cnt_q : wrd[AW-1:0]),
                .wdata_a (own ? fill_pat_q : write_data_i),
                .rdata_a (bank_rd_a[g]),
                .addr_b  (disp_addr_i),
                .rdata_b (bank_rd_b[g])
            );
        end else begin : g_none
            assign bank_rd_a[g] = UNMAPPED_RDATA;
            assign bank_rd_b[g] = UNMAPPED_RDATA;
        end
    end

    assign read_data_o  = (rd_src_q < SEL_W'(NUM_REGIONS)) ? bank_rd_a[rd_src_q] : csr_rdata_q;
    assign disp_rdata_o = bank_rd_b[disp_sel_q];

endmodule
